// File: rtl/wdt_reg_ctrl.sv
// wdt_reg_ctrl: system-clock register front end for the watchdog timer (CTRL/LIVE/WTOCNT/STATUS).
// Define WDT_LOCK_EN to add the KEY register that one-shot unlocks CTRL and WTOCNT writes.

module wdt_reg_ctrl #(
  parameter int          ADDR_W      = 8,
  parameter int          LOAD_CYCLES = 8,
  parameter int          LIVE_CYCLES = 8,
  parameter logic [31:0] LOCK_KEY    = 32'h5A5A_A5A5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              WDEN,
  output logic              WDLIVE,
  output logic [31:0]       WTOCNT,
  output logic              WTOCNT_load,
  input  logic              WTO,
  output logic              wdt_irq
);

  localparam int HOLD_MAX = (LOAD_CYCLES > LIVE_CYCLES) ? LOAD_CYCLES : LIVE_CYCLES;
  localparam int CNT_W    = $clog2(HOLD_MAX) + 1;
  localparam int WORD_W   = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LIVE, S_GAP} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              irq_en, to_pend;
  logic              wto_s1, wto_sync, wto_s3;
  logic [WORD_W-1:0] word;
  logic              sel_ctrl, sel_live, sel_cnt, sel_status, sel_key;
  logic              lock_ok, req_err, accept, wr_ok;
  logic              do_ctrl, do_live, do_cnt, pend_clr;
  logic [31:0]       rdata_d;

  // Back-pressure while a strobe is stretched keeps WDEN/WTOCNT frozen under WTOCNT_load.
  assign req_ready  = (state == S_IDLE);
  assign accept     = req_valid & req_ready;
  assign word       = req_addr[ADDR_W-1:2];
  assign sel_ctrl   = (word == WORD_W'(0));
  assign sel_live   = (word == WORD_W'(1));
  assign sel_cnt    = (word == WORD_W'(2));
  assign sel_status = (word == WORD_W'(3));

`ifdef WDT_LOCK_EN
  logic armed;
  logic unused_ok;
  assign sel_key   = (word == WORD_W'(4));
  assign lock_ok   = armed;
  assign unused_ok = ^req_addr[1:0];
`else
  logic unused_ok;
  assign sel_key   = 1'b0;
  assign lock_ok   = 1'b1;
  assign unused_ok = ^{LOCK_KEY, req_addr[1:0]};
`endif

  assign req_err  = ~(sel_ctrl | sel_live | sel_cnt | sel_status | sel_key)
                  | (req_we & (sel_ctrl | sel_cnt) & ~lock_ok);
  assign wr_ok    = accept & req_we & ~req_err;
  assign do_ctrl  = wr_ok & sel_ctrl;
  assign do_live  = wr_ok & sel_live;
  assign do_cnt   = wr_ok & sel_cnt;
  assign pend_clr = wr_ok & sel_status & req_wdata[1];

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    rdata_d = '0;
    if (!req_we && !req_err) begin
      if (sel_ctrl)        rdata_d = {30'd0, irq_en, WDEN};
      else if (sel_cnt)    rdata_d = WTOCNT;
      else if (sel_status) rdata_d = {30'd0, to_pend, wto_sync};
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (do_cnt) begin
          state_next = S_LOAD;
          cnt_next   = CNT_W'(LOAD_CYCLES);
        end else if (do_live) begin
          state_next = S_LIVE;
          cnt_next   = CNT_W'(LIVE_CYCLES);
        end
      end
      S_LOAD, S_LIVE: begin
        if (cnt == CNT_W'(1)) state_next = S_GAP;
        else                  cnt_next   = cnt - CNT_W'(1);
      end
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes come straight from flops so the WDT-domain synchronisers see glitch-free levels.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all flop state so every flop samples pre-edge values.
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      WTOCNT_load <= 1'b0;
      WDLIVE      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      WTOCNT_load <= (state_next == S_LOAD);
      WDLIVE      <= (state_next == S_LIVE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WDEN      <= 1'b0;
      irq_en    <= 1'b0;
      WTOCNT    <= '0;
      to_pend   <= 1'b0;
      wdt_irq   <= 1'b0;
      wto_s1    <= 1'b0;
      wto_sync  <= 1'b0;
      wto_s3    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      wto_s1    <= WTO;
      wto_sync  <= wto_s1;
      wto_s3    <= wto_sync;
      // A rising edge landing on the same cycle as a W1C keeps the pending bit set.
      to_pend   <= (wto_sync & ~wto_s3) | (to_pend & ~pend_clr);
      wdt_irq   <= to_pend & irq_en;
      rsp_valid <= accept;
      rsp_rdata <= accept ? rdata_d : 32'd0;
      rsp_err   <= accept & req_err;
      if (do_ctrl) begin
        WDEN   <= req_wdata[0];
        irq_en <= req_wdata[1];
      end
      if (do_cnt) WTOCNT <= req_wdata;
    end
  end

`ifdef WDT_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst)                        armed <= 1'b0;
    else if (wr_ok & sel_key)       armed <= (req_wdata == LOCK_KEY);
    else if (do_ctrl | do_cnt)      armed <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_wdt_reg_ctrl.sv
// tb_wdt_reg_ctrl: directed plus randomized bus traffic against a register-map model of wdt_reg_ctrl.
// Build with +define+WDT_LOCK_EN to exercise the key-protected variant.

module tb_wdt_reg_ctrl;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;
`ifdef WDT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        WDEN, WDLIVE, WTOCNT_load, WTO, wdt_irq;
  logic [31:0] WTOCNT;

  always #5 clk = ~clk;

  wdt_reg_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT), .WTOCNT_load(WTOCNT_load),
    .WTO(WTO), .wdt_irq(wdt_irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Register-map model
  bit          m_wden, m_irq_en, m_to_pend, m_wto, m_armed, m_rise_now;
  logic [31:0] m_wtocnt;
  int          last_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wden = 0; m_irq_en = 0; m_to_pend = 0; m_armed = 0; m_rise_now = 0;
    m_wtocnt = '0;
  endtask

  // Presents a request at the current negedge, returns at the negedge holding the response.
  task automatic do_req(input bit we, input logic [7:0] addr, input logic [31:0] wdata,
                        output bit ok);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    last_wait = 0; ok = 1'b1;
    while (!req_ready && last_wait < 40) begin
      @(negedge clk);
      last_wait++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      ok = 1'b0;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
  endtask

  task automatic check_hold(input bit is_load);
    int hi = 0, busy = 0;
    bit done = 0, bad = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) begin
        done = 1;
        if (WTOCNT_load || WDLIVE) bad = 1;
      end else begin
        busy++;
        if (is_load ? WTOCNT_load : WDLIVE) hi++;
        if (is_load ? WDLIVE : WTOCNT_load) bad = 1;
        if (WTOCNT_load && (WTOCNT !== m_wtocnt || WDEN !== m_wden)) bad = 1;
        @(negedge clk);
      end
    end
    check("hold_done", 32'(done), 32'd1);
    check(is_load ? "load_len" : "live_len", 32'(hi), 32'd8);
    check("busy_len", 32'(busy), 32'd9);
    check("hold_clean", 32'(bad), 32'd0);
  endtask

  task automatic xact(input bit we, input logic [7:0] addr, input logic [31:0] wdata,
                      input bit skip_post);
    logic [5:0]  w;
    bit          mapped, exp_err, ok;
    logic [31:0] exp_rdata;
    int          hold;
    w = addr[7:2];
    mapped = (w <= 6'd3) || (LOCK && w == 6'd4);
    exp_err = !mapped || (LOCK && we && (w == 6'd0 || w == 6'd2) && !m_armed);
    exp_rdata = '0;
    hold = 0;
    if (!we && mapped) begin
      case (w)
        6'd0: exp_rdata = {30'd0, m_irq_en, m_wden};
        6'd2: exp_rdata = m_wtocnt;
        6'd3: exp_rdata = {30'd0, m_to_pend, m_wto};
        default: exp_rdata = '0;
      endcase
    end
    if (we && !exp_err) begin
      case (w)
        6'd0: begin m_wden = wdata[0]; m_irq_en = wdata[1]; m_armed = 0; end
        6'd1: hold = 2;
        6'd2: begin m_wtocnt = wdata; hold = 1; m_armed = 0; end
        6'd3: if (wdata[1]) m_to_pend = 0;
        6'd4: m_armed = (wdata == KEY);
        default: ;
      endcase
    end
    if (m_rise_now) m_to_pend = 1;
    m_rise_now = 0;
    do_req(we, addr, wdata, ok);
    if (!ok) return;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    if (skip_post) return;
    if (hold != 0) check_hold(hold == 1);
    else begin
      @(negedge clk);
      check("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    end
    check("WDEN", 32'(WDEN), 32'(m_wden));
    check("WTOCNT", WTOCNT, m_wtocnt);
    check("wdt_irq", 32'(wdt_irq), 32'(m_to_pend & m_irq_en));
  endtask

  task automatic unlock();
`ifdef WDT_LOCK_EN
    xact(1'b1, 8'h10, KEY, 1'b0);
`endif
  endtask

  task automatic set_wto(input bit v);
    WTO = v;
    repeat (4) @(negedge clk);
    if (v && !m_wto) m_to_pend = 1;
    m_wto = v;
    check("wdt_irq_wto", 32'(wdt_irq), 32'(m_to_pend & m_irq_en));
  endtask

  initial begin
    bit ok;
    rst = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; WTO = 0;
    model_reset(); m_wto = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_outputs", {26'd0, WDEN, WDLIVE, WTOCNT_load, wdt_irq, rsp_err, 1'b0}, 32'd0);
    check("rst_wtocnt", WTOCNT, 32'd0);

    // WTOCNT load strobe
    unlock();
    xact(1'b1, 8'h08, 32'h1000, 1'b0);

    // LIVE request held off by an active load
    unlock();
    xact(1'b1, 8'h08, 32'h2222_3333, 1'b1);
    xact(1'b1, 8'h04, 32'h0, 1'b0);
    check("live_wait", 32'(last_wait), 32'd9);

    // Timeout interrupt, W1C with WTO still high
    unlock();
    xact(1'b1, 8'h00, 32'h2, 1'b0);
    set_wto(1'b1);
    xact(1'b0, 8'h0C, 32'h0, 1'b0);
    xact(1'b1, 8'h0C, 32'h2, 1'b0);
    xact(1'b0, 8'h0C, 32'h0, 1'b0);

    // Rising edge coincident with a W1C: the set survives
    set_wto(1'b0);
    WTO = 1'b1; m_wto = 1;
    @(negedge clk); @(negedge clk);
    m_rise_now = 1;
    xact(1'b1, 8'h0C, 32'h2, 1'b0);
    xact(1'b0, 8'h0C, 32'h0, 1'b0);
    xact(1'b1, 8'h0C, 32'h2, 1'b0);
    set_wto(1'b0);

    // Unmapped address, CTRL reserved bits
    xact(1'b0, 8'h14, 32'h0, 1'b0);
    xact(1'b1, 8'h14, 32'hDEAD_BEEF, 1'b0);
    unlock();
    xact(1'b1, 8'h00, 32'hFFFF_FFFF, 1'b0);
    xact(1'b0, 8'h00, 32'h0, 1'b0);

    // Reset in the middle of a load hold
    unlock();
    do_req(1'b1, 8'h08, 32'h0000_ABCD, ok);
    check("midhold_load", 32'(WTOCNT_load), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midhold_ready", 32'(req_ready), 32'd1);
    check("midhold_outputs", {27'd0, WDEN, WDLIVE, WTOCNT_load, wdt_irq, rsp_valid}, 32'd0);
    check("midhold_wtocnt", WTOCNT, 32'd0);

`ifdef WDT_LOCK_EN
    xact(1'b1, 8'h00, 32'h1, 1'b0);
    check("lock_wden_blocked", 32'(WDEN), 32'd0);
    xact(1'b1, 8'h10, KEY, 1'b0);
    xact(1'b1, 8'h00, 32'h1, 1'b0);
    check("lock_wden_set", 32'(WDEN), 32'd1);
    xact(1'b1, 8'h00, 32'h0, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) set_wto(!m_wto);
      else begin
        int          sel;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] data;
        sel = $urandom_range(0, 6);
        we  = 1'($urandom_range(0, 1));
        case (sel)
          0: addr = 8'h00;
          1: addr = 8'h04;
          2: addr = 8'h08;
          3: addr = 8'h0C;
          4: addr = 8'h10;
          5: addr = 8'h14;
          default: addr = 8'($urandom_range(0, 255));
        endcase
        addr[1:0] = 2'($urandom_range(0, 3));
        data = (sel == 4 && $urandom_range(0, 1) == 1) ? KEY : $urandom;
        xact(we, addr, data, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
